// File: rtl/spi_slave_if.sv
// SPI slave bus bundle: serial pins plus the parallel memory-side handshake.
// The slave modport is the view of the spi_slave block; master is the view of
// whatever drives the serial lines and serves reads (for example a testbench).
interface spi_slave_if;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave with a 10-bit command/address/data frame and an 8-bit read reply.
// Frame layout: bit 9 selects write (0) or read (1). A read is two frames:
// the first carries the address (READ_ADD), the second triggers the reply
// (READ_DATA), after which the memory byte is shifted out on MISO.
// Optional feature: define SPI_TX_TIMEOUT_EN to abandon a read reply when
// tx_valid does not arrive within TIMEOUT_CYCLES clocks; without it the block
// waits for tx_valid for as long as SS_n stays low.
module spi_slave #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_slave_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  // A zero timeout would make the read-reply wait meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("spi_slave: TIMEOUT_CYCLES must be at least 1");
  end

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] tx_cnt_q, tx_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_busy_q, tx_busy_d;
  logic       tx_done_q, tx_done_d;
  logic [9:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       miso_q, miso_d;
  logic       rd_addr_done_q, rd_addr_done_d;

`ifdef SPI_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  // State and datapath registers; reset is asynchronous and clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      tx_cnt_q       <= '0;
      tx_shift_q     <= '0;
      tx_busy_q      <= 1'b0;
      tx_done_q      <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      rd_addr_done_q <= 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
      to_cnt_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_shift_q     <= tx_shift_d;
      tx_busy_q      <= tx_busy_d;
      tx_done_q      <= tx_done_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      miso_q         <= miso_d;
      rd_addr_done_q <= rd_addr_done_d;
`ifdef SPI_TX_TIMEOUT_EN
      to_cnt_q       <= to_cnt_d;
`endif
    end
  end

  // Next state: SS_n high always returns to IDLE; the command bit picks the path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!bus.SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        if (bus.SS_n)           state_d = IDLE;
        else if (!bus.MOSI)     state_d = WRITE;
        else if (rd_addr_done_q) state_d = READ_DATA;
        else                    state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (bus.SS_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: frame shifting, rx_valid strobe, read-reply serialisation.
  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    tx_cnt_d       = tx_cnt_q;
    tx_shift_d     = tx_shift_q;
    tx_busy_d      = tx_busy_q;
    tx_done_d      = tx_done_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = miso_q;
    rd_addr_done_d = rd_addr_done_q;
`ifdef SPI_TX_TIMEOUT_EN
    to_cnt_d       = to_cnt_q;
`endif

    if (bus.SS_n) begin
      // Deselect wins over everything, including a 10th bit on the same edge.
      bit_cnt_d = '0;
      tx_cnt_d  = '0;
      tx_busy_d = 1'b0;
      tx_done_d = 1'b0;
      miso_d    = 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
      to_cnt_d  = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          tx_cnt_d  = '0;
          tx_busy_d = 1'b0;
          tx_done_d = 1'b0;
          miso_d    = 1'b0;
        end

        CHK_CMD: begin
          rx_data_d[9] = bus.MOSI;
          bit_cnt_d    = '0;
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (bit_cnt_q < 4'd9) begin
            // Still collecting the 9 bits that follow the command bit.
            rx_data_d[8:0] = {rx_data_q[7:0], bus.MOSI};
            bit_cnt_d      = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd8) begin
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) rd_addr_done_d = 1'b1;
            end
          end else if (state_q == READ_DATA) begin
            if (tx_busy_q) begin
              // Bits 6..0 follow the captured MSB, then MISO returns low.
              if (tx_cnt_q == 3'd7) begin
                miso_d         = 1'b0;
                tx_busy_d      = 1'b0;
                tx_done_d      = 1'b1;
                rd_addr_done_d = 1'b0;
              end else begin
                miso_d     = tx_shift_q[7];
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
                tx_cnt_d   = tx_cnt_q + 3'd1;
              end
            end else if (!tx_done_q) begin
              // Waiting for the memory to present the read byte.
              if (bus.tx_valid) begin
                miso_d     = bus.tx_data[7];
                tx_shift_d = {bus.tx_data[6:0], 1'b0};
                tx_cnt_d   = '0;
                tx_busy_d  = 1'b1;
`ifdef SPI_TX_TIMEOUT_EN
              end else if (to_cnt_q == TO_LAST) begin
                tx_done_d      = 1'b1;
                rd_addr_done_d = 1'b0;
                miso_d         = 1'b0;
              end else begin
                to_cnt_d = to_cnt_q + 1'b1;
`endif
              end
            end
          end
        end

        default: begin
          miso_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave: write, two-frame read, aborts,
// async reset during a reply, and the tx_valid timeout option.
module tb_spi_slave;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  spi_slave_if bus ();

  spi_slave #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's worth of inputs, then wait past the edge for outputs.
  task automatic applyStimulus(input logic ss, input logic mosi,
                               input logic txv, input logic [7:0] txd);
    bus.SS_n     = ss;
    bus.MOSI     = mosi;
    bus.tx_valid = txv;
    bus.tx_data  = txd;
    @(posedge clk);
    #1;
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Select edge plus 10 frame bits; reports rx_valid pulses, data, MISO activity.
  task automatic sendFrame(input logic [9:0] frame, output int pulses,
                           output logic [9:0] got, output logic miso_any);
    pulses   = 0;
    got      = '0;
    miso_any = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 9; i >= 0; i--) begin
      applyStimulus(1'b0, frame[i], 1'b0, 8'h00);
      if (bus.rx_valid) begin
        pulses++;
        got = bus.rx_data;
      end
      miso_any = miso_any | bus.MISO;
    end
  endtask

  // Offer a byte with tx_valid and collect the 8 MISO bits plus the trailing level.
  task automatic readByte(input logic [7:0] txd, output logic [7:0] got,
                          output logic tail);
    applyStimulus(1'b0, 1'b0, 1'b1, txd);
    got[7] = bus.MISO;
    for (int i = 6; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      got[i] = bus.MISO;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tail = bus.MISO;
  endtask

  // Run n edges with tx_valid held and report whether MISO ever went high.
  task automatic watchMiso(input int n, input logic txv, output logic any);
    any = 1'b0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, txv, 8'hFF);
      any = any | bus.MISO;
    end
  endtask

  initial begin
    int         pulses;
    logic [9:0] got;
    logic       miso_any;
    logic [7:0] byte_got;
    logic       tail;
    logic [3:0] nib;

    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    // Reset state, before any clock edge.
    #1;
    checkOutput("reset_miso", 32'(bus.MISO), 32'h0);
    checkOutput("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
    checkOutput("reset_rx_data", 32'(bus.rx_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

    // Write frame 0_0_0x3C.
    $display("[TB] write frame 0x03C");
    sendFrame(10'h03C, pulses, got, miso_any);
    checkOutput("wr_pulses", 32'(pulses), 32'd1);
    checkOutput("wr_data", 32'(got), 32'h03C);
    checkOutput("wr_miso", 32'(miso_any), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("wr_valid_clear", 32'(bus.rx_valid), 32'h0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      if (bus.rx_valid) pulses++;
    end
    checkOutput("wr_extra_bits_pulses", 32'(pulses), 32'd0);
    checkOutput("wr_extra_bits_hold", 32'(bus.rx_data), 32'h03C);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

    // Read address then read data with byte 0xC3.
    $display("[TB] read 0x2A5 / 0x3FF, byte 0xC3");
    sendFrame(10'h2A5, pulses, got, miso_any);
    checkOutput("rdadd_pulses", 32'(pulses), 32'd1);
    checkOutput("rdadd_data", 32'(got), 32'h2A5);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    sendFrame(10'h3FF, pulses, got, miso_any);
    checkOutput("rddat_pulses", 32'(pulses), 32'd1);
    checkOutput("rddat_data", 32'(got), 32'h3FF);
    watchMiso(3, 1'b0, miso_any);
    checkOutput("rddat_wait_miso", 32'(miso_any), 32'h0);
    readByte(8'hC3, byte_got, tail);
    checkOutput("rddat_byte", 32'(byte_got), 32'hC3);
    checkOutput("rddat_tail", 32'(tail), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    // rd_addr_done now clear: a 1-prefixed frame is an address, tx_valid ignored.
    sendFrame(10'h3FF, pulses, got, miso_any);
    checkOutput("rdadd2_pulses", 32'(pulses), 32'd1);
    watchMiso(9, 1'b1, miso_any);
    checkOutput("rdadd2_no_reply", 32'(miso_any), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

    // Abort a write after 5 bits, then a full 0x155 frame.
    $display("[TB] abort after 5 bits, then 0x155");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      if (bus.rx_valid) pulses++;
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    if (bus.rx_valid) pulses++;
    checkOutput("abort_pulses", 32'(pulses), 32'd0);
    sendFrame(10'h155, pulses, got, miso_any);
    checkOutput("after_abort_pulses", 32'(pulses), 32'd1);
    checkOutput("after_abort_data", 32'(got), 32'h155);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

    // SS_n rises on the edge of the 10th bit: no strobe.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      if (bus.rx_valid) pulses++;
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    if (bus.rx_valid) pulses++;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    if (bus.rx_valid) pulses++;
    checkOutput("ss_on_10th_pulses", 32'(pulses), 32'd0);

    // Address is latched (from 0x3FF above); abort a reply after 4 bits, then retry.
    $display("[TB] reply abort and retry");
    sendFrame(10'h3AA, pulses, got, miso_any);
    checkOutput("retry1_data", 32'(got), 32'h3AA);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hC3);
    nib[3] = bus.MISO;
    for (int i = 2; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      nib[i] = bus.MISO;
    end
    checkOutput("retry1_nibble", 32'(nib), 32'hC);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("retry1_abort_miso", 32'(bus.MISO), 32'h0);
    sendFrame(10'h300, pulses, got, miso_any);
    checkOutput("retry2_data", 32'(got), 32'h300);
    readByte(8'h81, byte_got, tail);
    checkOutput("retry2_byte", 32'(byte_got), 32'h81);
    checkOutput("retry2_tail", 32'(tail), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

    // Async reset in the middle of a reply.
    $display("[TB] async reset during reply");
    sendFrame(10'h211, pulses, got, miso_any);
    checkOutput("rst_pre_addr", 32'(got), 32'h211);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    sendFrame(10'h3F0, pulses, got, miso_any);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rst_pre_miso", 32'(bus.MISO), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_miso", 32'(bus.MISO), 32'h0);
    checkOutput("rst_mid_rx_valid", 32'(bus.rx_valid), 32'h0);
    checkOutput("rst_mid_rx_data", 32'(bus.rx_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sendFrame(10'h3C3, pulses, got, miso_any);
    checkOutput("rst_post_pulses", 32'(pulses), 32'd1);
    checkOutput("rst_post_data", 32'(got), 32'h3C3);
    watchMiso(9, 1'b1, miso_any);
    checkOutput("rst_post_read_add", 32'(miso_any), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

    // Late tx_valid: timeout option abandons the reply, default build waits.
    sendFrame(10'h3A5, pulses, got, miso_any);
    checkOutput("late_data", 32'(got), 32'h3A5);
`ifdef SPI_TX_TIMEOUT_EN
    $display("[TB] tx_valid timeout enabled");
    watchMiso(8, 1'b0, miso_any);
    checkOutput("to_wait_miso", 32'(miso_any), 32'h0);
    watchMiso(3, 1'b1, miso_any);
    checkOutput("to_ignored_miso", 32'(miso_any), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    sendFrame(10'h201, pulses, got, miso_any);
    checkOutput("to_next_pulses", 32'(pulses), 32'd1);
    watchMiso(9, 1'b1, miso_any);
    checkOutput("to_next_read_add", 32'(miso_any), 32'h0);
`else
    $display("[TB] tx_valid timeout disabled");
    watchMiso(20, 1'b0, miso_any);
    checkOutput("late_wait_miso", 32'(miso_any), 32'h0);
    readByte(8'hA5, byte_got, tail);
    checkOutput("late_byte", 32'(byte_got), 32'hA5);
    checkOutput("late_tail", 32'(tail), 32'h0);
`endif
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 8, clk cycles to wait for tx_valid in READ_DATA (used only with SPI_TX_TIMEOUT_EN).
REQ-002 clk  input  1  SPI serial clock; all logic on posedge clk; one clock domain.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SS_n  input  1  slave select, active-low; frames a transaction.
REQ-005 MOSI  input  1  serial data in, MSB first, sampled on posedge clk.
REQ-006 MISO  output  1  serial data out, registered, MSB first.
REQ-007 rx_data  output  10  parallel frame to memory; [9:8] command, [7:0] address/data.
REQ-008 rx_valid  output  1  one-cycle strobe; rx_data valid while high.
REQ-009 tx_data  input  8  read data from memory.
REQ-010 tx_valid  input  1  tx_data valid strobe from memory.

Function
REQ-011 The block SHALL implement FSM states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, plus an internal flag rd_addr_done.
REQ-012 IDLE: SS_n=0 at a posedge SHALL move to CHK_CMD; otherwise stay.
REQ-013 CHK_CMD: the MOSI bit sampled becomes rx_data[9]; MOSI=0 -> WRITE; MOSI=1 and rd_addr_done=0 -> READ_ADD; MOSI=1 and rd_addr_done=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA SHALL shift the next 9 MOSI bits into rx_data[8:0], MSB first, via a 4-bit bit counter.
REQ-015 rx_valid SHALL be set on the edge sampling the 10th frame bit and cleared on the next edge (exactly one cycle high); rx_data SHALL hold stable while rx_valid is high.
REQ-016 READ_ADD: on completing the 10-bit frame, rd_addr_done SHALL set to 1.
REQ-017 WRITE/READ_ADD: MOSI bits after the 10th SHALL be ignored (no further rx_valid) until SS_n=1.
REQ-018 READ_DATA: after rx_valid, the block SHALL wait for tx_valid=1; on that edge it SHALL capture tx_data and drive MISO=tx_data[7].
REQ-019 The following 7 edges SHALL drive MISO=tx_data[6..0] via a 3-bit counter; the edge after bit 0 SHALL drive MISO=0 and clear rd_addr_done.
REQ-020 tx_valid outside the READ_DATA wait phase SHALL be ignored; MISO SHALL be 0 whenever not transmitting.
REQ-021 SS_n=1 at any posedge in any non-IDLE state SHALL return the FSM to IDLE on that edge, clear counters, force MISO=0 and rx_valid=0; a partial frame SHALL produce no rx_valid.
REQ-022 Aborting READ_DATA before all 8 MISO bits SHALL leave rd_addr_done=1 (read may be retried).
REQ-023 SS_n=1 on the same edge as the 10th bit SHALL take priority: no rx_valid, state IDLE.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, rx_data=0, rx_valid=0, MISO=0, rd_addr_done=0, all counters 0.
REQ-025 Reset mid-transaction SHALL discard the frame; first edge after release behaves as IDLE.

Configuration
REQ-026 Macro SPI_TX_TIMEOUT_EN SHALL select tx_valid timeout behaviour.
REQ-027 Defined: if tx_valid does not arrive within TIMEOUT_CYCLES edges after rx_valid in READ_DATA, the block SHALL clear rd_addr_done, keep MISO=0, and ignore MOSI/tx_valid until SS_n=1.
REQ-028 Undefined: the block SHALL wait for tx_valid indefinitely while SS_n=0; no timeout counter SHALL exist.

Verification
REQ-029 Write: SS_n=0, MOSI 0_0_0x3C -> one rx_valid, rx_data=10'h03C; MISO=0 throughout.
REQ-030 Read address then data: frame 10'h2A5, SS_n high, frame 10'h3FF, memory returns tx_valid with 8'hC3 -> rx_data 10'h2A5 then 10'h3FF; MISO 1,1,0,0,0,0,1,1; rd_addr_done 0 afterwards.
REQ-031 Abort: SS_n=1 after 5 bits of a write frame -> no rx_valid, state IDLE; next full frame 10'h155 decodes correctly.
REQ-032 Async reset: assert rst_n=0 mid READ_DATA MISO shift -> MISO=0, rx_valid=0 immediately; subsequent 1-prefixed frame enters READ_ADD.
REQ-033 Timeout (SPI_TX_TIMEOUT_EN defined): READ_DATA frame, tx_valid withheld 8 cycles -> MISO stays 0, next 1-prefixed frame enters READ_ADD; undefined: tx_valid after 20 cycles still yields correct MISO byte.
